paket_denetleyici: RTL and testbench



---
 rtl/paket_denetleyici_pkg.sv | 22 ++
 rtl/paket_denetleyici_saglama_birimi.sv | 45 ++++
 rtl/paket_denetleyici.sv | 183 ++++++++++++++++++
 tb/tb_paket_denetleyici.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/paket_denetleyici_pkg.sv
// Shared constants and state encodings for the packet framing controller.
package paket_denetleyici_pkg;

    localparam int VARSAYILAN_DATA_W    = 8;
    localparam int VARSAYILAN_LEN_WORDS = 2;

    localparam int CHK_TOPLAM = 0;
    localparam int CHK_XOR    = 1;

    typedef enum logic [1:0] {
        UZUNLUK = 2'd0,
        GOREV   = 2'd1,
        YUK     = 2'd2
    } rx_durum_t;

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        AKTAR   = 2'd1,
        SAGLAMA = 2'd2
    } tx_durum_t;

endpackage

// File: rtl/paket_denetleyici_saglama_birimi.sv
// Checksum accumulator: folds accepted result words by modular add or XOR.
module saglama_birimi
    import paket_denetleyici_pkg::*;
#(
    parameter int DATA_W = VARSAYILAN_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              temizle_i,
    input  logic              etkin_i,
    input  logic              mod_i,
    input  logic [DATA_W-1:0] veri_i,
    output logic [DATA_W-1:0] saglama_o
);

    logic [DATA_W-1:0] saglama_r;

    function automatic logic [DATA_W-1:0] katla(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] d,
        input logic              m
    );
        if (m) begin
            return acc ^ d;
        end else begin
            return acc + d;
        end
    endfunction

    // Accumulator register; clear wins over enable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            saglama_r <= '0;
        end else if (temizle_i) begin
            saglama_r <= '0;
        end else if (etkin_i) begin
            saglama_r <= katla(saglama_r, veri_i, mod_i);
        end else begin
            saglama_r <= saglama_r;
        end
    end

    assign saglama_o = saglama_r;

endmodule

// File: rtl/paket_denetleyici.sv
// Packet framing controller: parses length/task header, forwards payload,
// passes results through and appends a checksum word.
module paket_denetleyici
    import paket_denetleyici_pkg::*;
#(
    parameter  int DATA_W    = VARSAYILAN_DATA_W,
    parameter  int LEN_WORDS = VARSAYILAN_LEN_WORDS,
    parameter  int CHK_MOD   = CHK_TOPLAM,
    localparam int LEN_W     = LEN_WORDS * DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] rx_veri_i,
    input  logic              rx_gecerli_i,
    output logic              rx_hazir_o,
    output logic [DATA_W-1:0] yuk_veri_o,
    output logic              yuk_gecerli_o,
    input  logic              yuk_hazir_i,
    output logic              basla_o,
    output logic [DATA_W-1:0] gorev_o,
    output logic [LEN_W-1:0]  uzunluk_o,
    input  logic [DATA_W-1:0] sonuc_veri_i,
    input  logic              sonuc_gecerli_i,
    input  logic              sonuc_son_i,
    output logic              sonuc_hazir_o,
    output logic [DATA_W-1:0] tx_veri_o,
    output logic              tx_gecerli_o,
    input  logic              tx_hazir_i,
    output logic              mesgul_o
);

    localparam int KW = $clog2(LEN_WORDS) + 1;

    rx_durum_t         rx_durum_r;
    tx_durum_t         tx_durum_r;
    logic [LEN_W-1:0]  uzunluk_acc_r;
    logic [LEN_W-1:0]  uzunluk_r;
    logic [LEN_W-1:0]  sayac_r;
    logic [KW-1:0]     kelime_r;
    logic [DATA_W-1:0] gorev_r;
    logic              basla_r;

    logic              mesgul_s;
    logic              rx_hazir_s;
    logic              yuk_gecerli_s;
    logic              sonuc_hazir_s;
    logic              tx_gecerli_s;
    logic [DATA_W-1:0] tx_veri_s;
    logic              rx_aktar_s;
    logic              sonuc_aktar_s;
    logic              tx_aktar_s;
    logic              temizle_s;
    logic              etkin_s;
    logic              mod_s;
    logic [DATA_W-1:0] saglama_s;

    // Busy covers the start-pulse cycle so a back-to-back header is held off
    assign mesgul_s      = (tx_durum_r != BOSTA) || basla_r;
    assign rx_aktar_s    = rx_gecerli_i && rx_hazir_s;
    assign sonuc_aktar_s = sonuc_gecerli_i && sonuc_hazir_s;
    assign tx_aktar_s    = tx_gecerli_s && tx_hazir_i;
    assign temizle_s     = (tx_durum_r == BOSTA) && basla_r;
    assign etkin_s       = (tx_durum_r == AKTAR) && sonuc_aktar_s;
    assign mod_s         = (CHK_MOD == CHK_XOR) ? 1'b1 : 1'b0;

    // Receive-side handshake and payload pass-through steering
    always_comb begin
        rx_hazir_s    = 1'b0;
        yuk_gecerli_s = 1'b0;
        case (rx_durum_r)
            UZUNLUK: rx_hazir_s = !mesgul_s;
            GOREV:   rx_hazir_s = 1'b1;
            YUK: begin
                rx_hazir_s    = yuk_hazir_i;
                yuk_gecerli_s = rx_gecerli_i;
            end
            default: rx_hazir_s = 1'b0;
        endcase
    end

    // Transmit-side steering: result pass-through or checksum word
    always_comb begin
        sonuc_hazir_s = 1'b0;
        tx_gecerli_s  = 1'b0;
        tx_veri_s     = '0;
        case (tx_durum_r)
            AKTAR: begin
                sonuc_hazir_s = tx_hazir_i;
                tx_gecerli_s  = sonuc_gecerli_i;
                tx_veri_s     = sonuc_veri_i;
            end
            SAGLAMA: begin
                tx_gecerli_s = 1'b1;
                tx_veri_s    = saglama_s;
            end
            default: tx_veri_s = '0;
        endcase
    end

    // Receive FSM: header parse, start pulse, payload word count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_durum_r    <= UZUNLUK;
            uzunluk_acc_r <= '0;
            uzunluk_r     <= '0;
            sayac_r       <= '0;
            kelime_r      <= '0;
            gorev_r       <= '0;
            basla_r       <= 1'b0;
        end else begin
            basla_r <= 1'b0;
            case (rx_durum_r)
                UZUNLUK: begin
                    if (rx_aktar_s) begin
                        // First length word restarts the big-endian shift
                        uzunluk_acc_r <= ((kelime_r == '0) ? '0 : (uzunluk_acc_r << DATA_W))
                                         | LEN_W'(rx_veri_i);
                        if (kelime_r == KW'(LEN_WORDS - 1)) begin
                            kelime_r   <= '0;
                            rx_durum_r <= GOREV;
                        end else begin
                            kelime_r <= kelime_r + KW'(1);
                        end
                    end
                end
                GOREV: begin
                    if (rx_aktar_s) begin
                        gorev_r    <= rx_veri_i;
                        basla_r    <= 1'b1;
                        uzunluk_r  <= uzunluk_acc_r;
                        sayac_r    <= uzunluk_acc_r;
                        rx_durum_r <= (uzunluk_acc_r == '0) ? UZUNLUK : YUK;
                    end
                end
                YUK: begin
                    if (rx_aktar_s) begin
                        sayac_r <= sayac_r - LEN_W'(1);
                        if (sayac_r == LEN_W'(1)) begin
                            rx_durum_r <= UZUNLUK;
                        end
                    end
                end
                default: rx_durum_r <= UZUNLUK;
            endcase
        end
    end

    // Transmit FSM: idle, result forwarding, checksum append
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_durum_r <= BOSTA;
        end else begin
            case (tx_durum_r)
                BOSTA:   if (basla_r) tx_durum_r <= AKTAR;
                AKTAR:   if (sonuc_aktar_s && sonuc_son_i) tx_durum_r <= SAGLAMA;
                SAGLAMA: if (tx_aktar_s) tx_durum_r <= BOSTA;
                default: tx_durum_r <= BOSTA;
            endcase
        end
    end

    saglama_birimi #(.DATA_W(DATA_W)) u_saglama (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .temizle_i (temizle_s),
        .etkin_i   (etkin_s),
        .mod_i     (mod_s),
        .veri_i    (sonuc_veri_i),
        .saglama_o (saglama_s)
    );

    assign rx_hazir_o    = rx_hazir_s;
    assign yuk_veri_o    = rx_veri_i;
    assign yuk_gecerli_o = yuk_gecerli_s;
    assign basla_o       = basla_r;
    assign gorev_o       = gorev_r;
    assign uzunluk_o     = uzunluk_r;
    assign sonuc_hazir_o = sonuc_hazir_s;
    assign tx_veri_o     = tx_veri_s;
    assign tx_gecerli_o  = tx_gecerli_s;
    assign mesgul_o      = mesgul_s;

endmodule

// File: tb/tb_paket_denetleyici.sv
// Directed bench: sum-mode DUT plus an XOR-mode twin on the same inputs.
module tb_paket_denetleyici;
    import paket_denetleyici_pkg::*;

    logic        clk;
    logic        rst_i;
    logic [7:0]  rx_veri_i;
    logic        rx_gecerli_i;
    logic        yuk_hazir_i;
    logic [7:0]  sonuc_veri_i;
    logic        sonuc_gecerli_i;
    logic        sonuc_son_i;
    logic        tx_hazir_i;

    logic        rx_hazir_o, yuk_gecerli_o, basla_o, sonuc_hazir_o, tx_gecerli_o, mesgul_o;
    logic [7:0]  yuk_veri_o, gorev_o, tx_veri_o;
    logic [15:0] uzunluk_o;

    logic        d1_rx_hazir, d1_yuk_gecerli, d1_basla, d1_sonuc_hazir, d1_tx_gecerli, d1_mesgul;
    logic [7:0]  d1_yuk_veri, d1_gorev, d1_tx_veri;
    logic [15:0] d1_uzunluk;

    int total = 0;
    int bad   = 0;
    int basla_say = 0;
    logic [7:0] yuk_q[$];
    logic [7:0] tx_q[$];

    paket_denetleyici #(.DATA_W(8), .LEN_WORDS(2), .CHK_MOD(CHK_TOPLAM)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .rx_veri_i(rx_veri_i), .rx_gecerli_i(rx_gecerli_i), .rx_hazir_o(rx_hazir_o),
        .yuk_veri_o(yuk_veri_o), .yuk_gecerli_o(yuk_gecerli_o), .yuk_hazir_i(yuk_hazir_i),
        .basla_o(basla_o), .gorev_o(gorev_o), .uzunluk_o(uzunluk_o),
        .sonuc_veri_i(sonuc_veri_i), .sonuc_gecerli_i(sonuc_gecerli_i),
        .sonuc_son_i(sonuc_son_i), .sonuc_hazir_o(sonuc_hazir_o),
        .tx_veri_o(tx_veri_o), .tx_gecerli_o(tx_gecerli_o), .tx_hazir_i(tx_hazir_i),
        .mesgul_o(mesgul_o)
    );

    paket_denetleyici #(.DATA_W(8), .LEN_WORDS(2), .CHK_MOD(CHK_XOR)) dut_xor (
        .clk_i(clk), .rst_i(rst_i),
        .rx_veri_i(rx_veri_i), .rx_gecerli_i(rx_gecerli_i), .rx_hazir_o(d1_rx_hazir),
        .yuk_veri_o(d1_yuk_veri), .yuk_gecerli_o(d1_yuk_gecerli), .yuk_hazir_i(yuk_hazir_i),
        .basla_o(d1_basla), .gorev_o(d1_gorev), .uzunluk_o(d1_uzunluk),
        .sonuc_veri_i(sonuc_veri_i), .sonuc_gecerli_i(sonuc_gecerli_i),
        .sonuc_son_i(sonuc_son_i), .sonuc_hazir_o(d1_sonuc_hazir),
        .tx_veri_o(d1_tx_veri), .tx_gecerli_o(d1_tx_gecerli), .tx_hazir_i(tx_hazir_i),
        .mesgul_o(d1_mesgul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat monitor on the falling edge, where inputs and outputs are settled
    always @(negedge clk) begin
        if (yuk_gecerli_o && yuk_hazir_i) yuk_q.push_back(yuk_veri_o);
        if (tx_gecerli_o && tx_hazir_i)   tx_q.push_back(tx_veri_o);
        if (basla_o)                      basla_say++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] w, input bit rnd, input string tag);
        bit done;
        done = 1'b0;
        rx_veri_i    = w;
        rx_gecerli_i = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            if (rnd) yuk_hazir_i = 1'($urandom_range(0, 1));
            #1;
            if (rnd) chk({tag, "_mirror"}, rx_hazir_o, yuk_hazir_i);
            done = rx_hazir_o;
            tick();
        end
        chk({tag, "_hs"}, done, 1'b1);
        rx_gecerli_i = 1'b0;
    endtask

    task automatic send_res(input logic [7:0] w, input logic son, input bit rnd, input string tag);
        bit done;
        done = 1'b0;
        sonuc_veri_i    = w;
        sonuc_son_i     = son;
        sonuc_gecerli_i = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            if (rnd) tx_hazir_i = 1'($urandom_range(0, 1));
            #1;
            if (rnd) chk({tag, "_mirror"}, sonuc_hazir_o, tx_hazir_i);
            done = sonuc_hazir_o;
            tick();
        end
        chk({tag, "_hs"}, done, 1'b1);
        sonuc_gecerli_i = 1'b0;
        sonuc_son_i     = 1'b0;
    endtask

    // Called one step after the son beat: checksum is on tx, then accepted
    task automatic finish_chk(input logic [7:0] e0, input logic [7:0] e1, input string tag);
        chk({tag, "_cs_vld"}, tx_gecerli_o, 1'b1);
        chk({tag, "_cs_sum"}, tx_veri_o, e0);
        chk({tag, "_cs_xor"}, d1_tx_veri, e1);
        tx_hazir_i = 1'b1;
        tick();
        chk({tag, "_idle"}, mesgul_o, 1'b0);
    endtask

    initial begin
        int err;
        rst_i = 1'b1; rx_veri_i = 8'h00; rx_gecerli_i = 1'b0; yuk_hazir_i = 1'b1;
        sonuc_veri_i = 8'h00; sonuc_gecerli_i = 1'b0; sonuc_son_i = 1'b0; tx_hazir_i = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rx_hazir", rx_hazir_o, 1'b1);
        chk("rst_yuk_vld", yuk_gecerli_o, 1'b0);
        chk("rst_basla", basla_o, 1'b0);
        chk("rst_gorev", gorev_o, 8'h00);
        chk("rst_uzunluk", uzunluk_o, 16'h0000);
        chk("rst_mesgul", mesgul_o, 1'b0);
        chk("rst_tx_vld", tx_gecerli_o, 1'b0);
        chk("rst_sonuc_hazir", sonuc_hazir_o, 1'b0);
        rst_i = 1'b0;
        tick();

        // Basic packet: header 00 03 05, payload AA BB CC, results 10 20 30
        yuk_q.delete(); tx_q.delete();
        send_rx(8'h00, 1'b0, "t1_h0");
        send_rx(8'h03, 1'b0, "t1_h1");
        send_rx(8'h05, 1'b0, "t1_gorev");
        chk("t1_basla", basla_o, 1'b1);
        chk("t1_gorev_o", gorev_o, 8'h05);
        chk("t1_uzunluk", uzunluk_o, 16'h0003);
        chk("t1_mesgul", mesgul_o, 1'b1);
        send_rx(8'hAA, 1'b0, "t1_p0");
        chk("t1_basla_1cyc", basla_o, 1'b0);
        send_rx(8'hBB, 1'b0, "t1_p1");
        send_rx(8'hCC, 1'b0, "t1_p2");
        chk("t1_yuk_n", yuk_q.size(), 3);
        chk("t1_yuk0", yuk_q[0], 8'hAA);
        chk("t1_yuk1", yuk_q[1], 8'hBB);
        chk("t1_yuk2", yuk_q[2], 8'hCC);
        send_res(8'h10, 1'b0, 1'b0, "t1_r0");
        send_res(8'h20, 1'b0, 1'b0, "t1_r1");
        send_res(8'h30, 1'b1, 1'b0, "t1_r2");
        finish_chk(8'h60, 8'h00, "t1");
        chk("t1_tx_n", tx_q.size(), 4);
        chk("t1_tx0", tx_q[0], 8'h10);
        chk("t1_tx1", tx_q[1], 8'h20);
        chk("t1_tx2", tx_q[2], 8'h30);
        chk("t1_tx3", tx_q[3], 8'h60);
        chk("t1_basla_say", basla_say, 1);

        // Sum wrap: results FF 02 -> 01 (XOR twin FD)
        send_rx(8'h00, 1'b0, "t2_h0");
        send_rx(8'h01, 1'b0, "t2_h1");
        send_rx(8'h0B, 1'b0, "t2_gorev");
        send_rx(8'h55, 1'b0, "t2_p0");
        send_res(8'hFF, 1'b0, 1'b0, "t2_r0");
        send_res(8'h02, 1'b1, 1'b0, "t2_r1");
        finish_chk(8'h01, 8'hFD, "t2");

        // Zero length, then a header held off while busy
        yuk_q.delete();
        send_rx(8'h00, 1'b0, "t3_h0");
        send_rx(8'h00, 1'b0, "t3_h1");
        send_rx(8'h07, 1'b0, "t3_gorev");
        chk("t3_basla", basla_o, 1'b1);
        chk("t3_gorev_o", gorev_o, 8'h07);
        chk("t3_uzunluk", uzunluk_o, 16'h0000);
        rx_veri_i = 8'h00; rx_gecerli_i = 1'b1;
        #1;
        chk("t3_hold0", rx_hazir_o, 1'b0);
        chk("t3_no_yuk", yuk_gecerli_o, 1'b0);
        tick();
        chk("t3_hold1", rx_hazir_o, 1'b0);
        send_res(8'h77, 1'b1, 1'b0, "t3_r0");
        chk("t3_hold_cs", rx_hazir_o, 1'b0);
        finish_chk(8'h77, 8'h77, "t3");
        chk("t3_release", rx_hazir_o, 1'b1);
        chk("t3_yuk_none", yuk_q.size(), 0);
        send_rx(8'h00, 1'b0, "t3b_h0");
        send_rx(8'h01, 1'b0, "t3b_h1");
        send_rx(8'h0D, 1'b0, "t3b_gorev");
        chk("t3b_gorev_o", gorev_o, 8'h0D);
        send_rx(8'h99, 1'b0, "t3b_p0");
        chk("t3b_yuk_n", yuk_q.size(), 1);
        chk("t3b_yuk0", yuk_q[0], 8'h99);
        send_res(8'h01, 1'b1, 1'b0, "t3b_r0");
        finish_chk(8'h01, 8'h01, "t3b");

        // 64-word payload with random stalls on both sides
        yuk_q.delete();
        send_rx(8'h00, 1'b0, "t4_h0");
        send_rx(8'h40, 1'b0, "t4_h1");
        send_rx(8'h21, 1'b0, "t4_gorev");
        chk("t4_uzunluk", uzunluk_o, 16'h0040);
        for (int i = 0; i < 64; i++) send_rx(8'(i + 1), 1'b1, "t4_p");
        yuk_hazir_i = 1'b1;
        #1;
        chk("t4_rx_blocked", rx_hazir_o, 1'b0);
        chk("t4_yuk_n", yuk_q.size(), 64);
        err = 0;
        foreach (yuk_q[k]) if (yuk_q[k] !== 8'(k + 1)) err++;
        chk("t4_yuk_seq", err, 0);
        send_res(8'h80, 1'b0, 1'b1, "t4_r");
        send_res(8'h90, 1'b0, 1'b1, "t4_r");
        send_res(8'hA0, 1'b0, 1'b1, "t4_r");
        send_res(8'hB0, 1'b0, 1'b1, "t4_r");
        send_res(8'hC0, 1'b1, 1'b1, "t4_r");
        tx_hazir_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("t4_cs_hold_vld", tx_gecerli_o, 1'b1);
            chk("t4_cs_hold_val", tx_veri_o, 8'h20);
            tick();
        end
        finish_chk(8'h20, 8'hC0, "t4");

        // Reset after 2 of 3 payload words, then a fresh packet
        send_rx(8'h00, 1'b0, "t5_h0");
        send_rx(8'h03, 1'b0, "t5_h1");
        send_rx(8'h0E, 1'b0, "t5_gorev");
        send_rx(8'h01, 1'b0, "t5_p0");
        send_rx(8'h02, 1'b0, "t5_p1");
        rst_i = 1'b1;
        tick();
        chk("t5_rst_rx_hazir", rx_hazir_o, 1'b1);
        chk("t5_rst_mesgul", mesgul_o, 1'b0);
        chk("t5_rst_gorev", gorev_o, 8'h00);
        chk("t5_rst_uzunluk", uzunluk_o, 16'h0000);
        chk("t5_rst_basla", basla_o, 1'b0);
        chk("t5_rst_tx_vld", tx_gecerli_o, 1'b0);
        chk("t5_rst_sonuc_hazir", sonuc_hazir_o, 1'b0);
        chk("t5_rst_yuk_vld", yuk_gecerli_o, 1'b0);
        rst_i = 1'b0;
        yuk_q.delete();
        send_rx(8'h00, 1'b0, "t5b_h0");
        send_rx(8'h01, 1'b0, "t5b_h1");
        send_rx(8'h09, 1'b0, "t5b_gorev");
        chk("t5b_basla", basla_o, 1'b1);
        chk("t5b_gorev_o", gorev_o, 8'h09);
        chk("t5b_uzunluk", uzunluk_o, 16'h0001);
        send_rx(8'h42, 1'b0, "t5b_p0");
        chk("t5b_yuk_n", yuk_q.size(), 1);
        chk("t5b_yuk0", yuk_q[0], 8'h42);
        send_res(8'h13, 1'b1, 1'b0, "t5b_r0");
        finish_chk(8'h13, 8'h13, "t5b");
        chk("basla_total", basla_say, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
